// File: rtl/hash_table_requester.sv
// rtl/hash_table_requester.sv - credit-based client front end for the cuckoo hash table pipeline
// Issues commands to the table, captures results after a fixed latency, queues them with tags.
module hash_table_requester #(
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [KEY_WIDTH-1:0]  cmd_key_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic [KEY_WIDTH-1:0]  ht_key_o,
  output logic [DATA_WIDTH-1:0] ht_data_o,
  output logic [1:0]            ht_op_o,
  output logic                  ht_valid_o,
  output logic                  ht_ready_o,
  input  logic [DATA_WIDTH-1:0] ht_read_data_i,
  input  logic                  ht_valid_i,
  input  logic [3:0]            ht_status_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_hit_o,
  output logic [3:0]            rsp_status_o
);

  localparam int UW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int RW = 2 + TAG_WIDTH + DATA_WIDTH + 1 + 4;

  logic [UW-1:0]        used;
  logic [TAG_WIDTH-1:0] tag_cnt;
  logic [TAG_WIDTH-1:0] iss_tag;
  logic                 accept;
  logic                 issue;
  logic                 push;
  logic                 pop;

  logic [LATENCY-1:0]   p_valid;
  logic [1:0]           p_op  [LATENCY];
  logic [TAG_WIDTH-1:0] p_tag [LATENCY];

  logic [RW-1:0]        mem [RESP_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [UW-1:0]        count;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready is gated by the reset input so both ready outputs read 0 while reset is held.
  assign cmd_ready_o = reset && (used < UW'(RESP_DEPTH));
  assign ht_ready_o  = reset;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign issue       = accept && (cmd_op_i != 2'b00);
  assign push        = p_valid[LATENCY-1];
  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

  assign {rsp_op_o, rsp_tag_o, rsp_data_o, rsp_hit_o, rsp_status_o} = mem[rd_ptr];

  // One credit per outstanding op: held from issue until its response is popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used    <= '0;
      tag_cnt <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
      if (issue) tag_cnt <= tag_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ht_key_o   <= '0;
      ht_data_o  <= '0;
      ht_op_o    <= 2'b00;
      ht_valid_o <= 1'b0;
      iss_tag    <= '0;
    end else if (issue) begin
      ht_key_o   <= cmd_key_i;
      ht_data_o  <= cmd_data_i;
      ht_op_o    <= cmd_op_i;
      ht_valid_o <= 1'b1;
      iss_tag    <= tag_cnt;
    end else begin
      ht_op_o    <= 2'b00;
      ht_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_op[i]  <= 2'b00;
        p_tag[i] <= '0;
      end
    end else begin
      p_valid[0] <= ht_valid_o;
      p_op[0]    <= ht_op_o;
      p_tag[0]   <= iss_tag;
      for (int i = 1; i < LATENCY; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_op[i]    <= p_op[i-1];
        p_tag[i]   <= p_tag[i-1];
      end
    end
  end

  // Credits guarantee a free slot for every push, so push never checks for full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {p_op[LATENCY-1], p_tag[LATENCY-1], ht_read_data_i, ht_valid_i, ht_status_i};
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_requester.sv
// tb/tb_hash_table_requester.sv - self-checking bench for hash_table_requester
// Behavioural table model feeds the DUT; expected responses are queued at accept and popped on rsp handshake.
module tb_hash_table_requester;

  localparam int KW = 2, DW = 32, LAT = 2, DEPTH = 4, TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = 2'b00;
  logic [KW-1:0] cmd_key_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic [KW-1:0] ht_key_o;
  logic [DW-1:0] ht_data_o;
  logic [1:0]    ht_op_o;
  logic          ht_valid_o;
  logic          ht_ready_o;
  logic [DW-1:0] ht_read_data_i;
  logic          ht_valid_i;
  logic [3:0]    ht_status_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [1:0]    rsp_op_o;
  logic [TW-1:0] rsp_tag_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_hit_o;
  logic [3:0]    rsp_status_o;

  hash_table_requester #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .LATENCY(LAT), .RESP_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_key_i(cmd_key_i), .cmd_data_i(cmd_data_i),
    .ht_key_o(ht_key_o), .ht_data_o(ht_data_o), .ht_op_o(ht_op_o),
    .ht_valid_o(ht_valid_o), .ht_ready_o(ht_ready_o),
    .ht_read_data_i(ht_read_data_i), .ht_valid_i(ht_valid_i), .ht_status_i(ht_status_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
    .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o), .rsp_hit_o(rsp_hit_o),
    .rsp_status_o(rsp_status_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    op;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          hit;
    logic [3:0]    st;
  } rsp_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          hit;
    logic [3:0]    st;
  } tres_t;

  rsp_t              exp_q[$];
  rsp_t              last_rsp;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                rsp_count = 0;
  int                hv_count = 0;
  int                first_acc_cyc = -1;
  int                first_rsp_cyc = -1;
  logic [TW-1:0]     exp_tag;
  logic [3:0]        sb_pres;
  logic [3:0][DW-1:0] sb_mem;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Table semantics: {key_already_present, no_element_found, no_write_space, no_deletion_target}.
  task automatic tbl_op(input logic [1:0] op, input logic [1:0] key, input logic [DW-1:0] din,
                        input logic [3:0] pres, input logic [3:0][DW-1:0] mem,
                        output logic [3:0] npres, output logic [3:0][DW-1:0] nmem,
                        output logic [DW-1:0] rd, output logic hit, output logic [3:0] st);
    npres = pres; nmem = mem; rd = '0; hit = 1'b0; st = 4'b0000;
    case (op)
      2'b01: if (pres[key]) begin hit = 1'b1; rd = mem[key]; end else st = 4'b0100;
      2'b10: if (pres[key]) st = 4'b1000; else begin npres[key] = 1'b1; nmem[key] = din; hit = 1'b1; end
      2'b11: if (pres[key]) begin npres[key] = 1'b0; hit = 1'b1; end else st = 4'b0001;
      default: ;
    endcase
  endtask

  tres_t              tp0, tp1;
  logic [3:0]         tbl_pres;
  logic [3:0][DW-1:0] tbl_mem;
  logic [DW-1:0]      junk;

  always @(posedge clk or negedge rst_n) begin : tbl_model
    logic [3:0]         np;
    logic [3:0][DW-1:0] nm;
    logic [DW-1:0]      rd;
    logic               hit;
    logic [3:0]         st;
    tres_t              r;
    if (!rst_n) begin
      tp0 <= '0; tp1 <= '0; tbl_pres <= '0; tbl_mem <= '0;
    end else begin
      r = '0; np = tbl_pres; nm = tbl_mem;
      if (ht_valid_o && ht_ready_o) begin
        tbl_op(ht_op_o, ht_key_o, ht_data_o, tbl_pres, tbl_mem, np, nm, rd, hit, st);
        r.v = 1'b1; r.d = rd; r.hit = hit; r.st = st;
      end
      tbl_pres <= np; tbl_mem <= nm;
      tp0 <= r; tp1 <= tp0;
    end
  end

  always @(posedge clk) junk <= $urandom;
  always @(posedge clk) cyc <= cyc + 1;

  // Outside the result slot the table outputs carry noise the DUT must ignore.
  assign ht_read_data_i = tp1.v ? tp1.d   : junk;
  assign ht_valid_i     = tp1.v ? tp1.hit : junk[0];
  assign ht_status_i    = tp1.v ? tp1.st  : junk[7:4];

  always @(negedge clk) begin
    if (rst_n) begin
      if (ht_valid_o) hv_count++;
      if (rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_count++;
        last_rsp = rsp_t'({rsp_op_o, rsp_tag_o, rsp_data_o, rsp_hit_o, rsp_status_o});
        if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        else chk("rsp", 64'(last_rsp), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string p);
    chk({p, "_ht_valid"}, 64'(ht_valid_o), 0);
    chk({p, "_ht_op"}, 64'(ht_op_o), 0);
    chk({p, "_ht_key"}, 64'(ht_key_o), 0);
    chk({p, "_ht_data"}, 64'(ht_data_o), 0);
    chk({p, "_ht_ready"}, 64'(ht_ready_o), 0);
    chk({p, "_cmd_ready"}, 64'(cmd_ready_o), 0);
    chk({p, "_rsp_valid"}, 64'(rsp_valid_o), 0);
    chk({p, "_rsp_fields"}, 64'({rsp_op_o, rsp_tag_o, rsp_data_o, rsp_hit_o, rsp_status_o}), 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_tag = '0; sb_pres = '0; sb_mem = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid_i = 1'b0;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready_o), 1);
    chk("post_rst_ht_ready", 64'(ht_ready_o), 1);
    rsp_count = 0; hv_count = 0; first_acc_cyc = -1; first_rsp_cyc = -1;
  endtask

  // Called just after a negedge; presents one command for one cycle.
  task automatic try_send(input logic [1:0] op, input logic [1:0] key, input logic [DW-1:0] data, output bit acc);
    logic [3:0] np; logic [3:0][DW-1:0] nm; logic [DW-1:0] rd; logic hit; logic [3:0] st;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_key_i = key; cmd_data_i = data;
    acc = cmd_ready_o;
    if (acc && op != 2'b00) begin
      tbl_op(op, key, data, sb_pres, sb_mem, np, nm, rd, hit, st);
      sb_pres = np; sb_mem = nm;
      exp_q.push_back('{op: op, tag: exp_tag, data: rd, hit: hit, st: st});
      exp_tag = exp_tag + 1'b1;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] key, input logic [DW-1:0] data);
    bit acc; int n;
    n = 0;
    do begin try_send(op, key, data, acc); n++; end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'(acc), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int accepted, rejects;

    // write then read the same key
    do_reset();
    send(2'b10, 2'b01, 32'hDEADBEEF);
    send(2'b01, 2'b01, 32'h0);
    wait_drain(50);
    chk("t1_rsp_count", 64'(rsp_count), 2);
    chk("t1_read_tag", 64'(last_rsp.tag), 1);
    chk("t1_read_hit", 64'(last_rsp.hit), 1);
    chk("t1_read_data", 64'(last_rsp.data), 64'hDEADBEEF);
    chk("t1_read_status", 64'(last_rsp.st), 0);

    // read of an absent key
    do_reset();
    send(2'b01, 2'b10, 32'h0);
    wait_drain(50);
    chk("t2_rsp_count", 64'(rsp_count), 1);
    chk("t2_hit", 64'(last_rsp.hit), 0);
    chk("t2_status2", 64'(last_rsp.st[2]), 1);

    // credit limit with a stalled consumer
    do_reset();
    rsp_ready_i = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(2'b10, 2'(i), 32'h1000 + 32'(i), acc);
      if (acc) accepted++;
    end
    chk("t3_accepted", 64'(accepted), 4);
    chk("t3_ready_low", 64'(cmd_ready_o), 0);
    repeat (6) @(negedge clk);
    chk("t3_ready_still_low", 64'(cmd_ready_o), 0);
    chk("t3_fifo_valid", 64'(rsp_valid_o), 1);
    chk("t3_head_tag", 64'(rsp_tag_o), 0);
    rsp_ready_i = 1'b1;
    send(2'b10, 2'b00, 32'h1004);
    send(2'b10, 2'b01, 32'h1005);
    wait_drain(60);
    chk("t3_rsp_count", 64'(rsp_count), 6);

    // NOPs interleaved with reads
    do_reset();
    send(2'b00, 2'b00, 32'h0);
    send(2'b01, 2'b00, 32'h0);
    send(2'b00, 2'b01, 32'h0);
    send(2'b00, 2'b10, 32'h0);
    send(2'b01, 2'b01, 32'h0);
    send(2'b00, 2'b11, 32'h0);
    send(2'b01, 2'b10, 32'h0);
    send(2'b00, 2'b00, 32'h0);
    wait_drain(50);
    chk("t4_rsp_count", 64'(rsp_count), 3);
    chk("t4_ht_valid_pulses", 64'(hv_count), 3);
    chk("t4_last_tag", 64'(last_rsp.tag), 2);

    // long read stream, tag wrap and first-response latency
    do_reset();
    rejects = 0;
    for (int i = 0; i < 20; i++) begin
      try_send(2'b01, 2'(i), 32'h0, acc);
      if (!acc) begin rejects++; i--; end
      if (rejects > 100) break;
    end
    wait_drain(100);
    chk("t5_rsp_count", 64'(rsp_count), 20);
    chk("t5_last_tag_wrapped", 64'(last_rsp.tag), 3);
    chk("t5_first_latency", 64'(first_rsp_cyc - first_acc_cyc), LAT + 2);

    // reset while results are in flight
    do_reset();
    send(2'b10, 2'b01, 32'hAAAA0001);
    send(2'b10, 2'b10, 32'hAAAA0002);
    send(2'b10, 2'b11, 32'hAAAA0003);
    chk("t6_in_flight", 64'(ht_valid_o), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_count = 0;
    repeat (12) @(negedge clk);
    chk("t6_no_rsp", 64'(rsp_count), 0);
    chk("t6_rsp_valid", 64'(rsp_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
